// File: rtl/ysyx_23060124_axi_sram_slave.sv
// AXI4-Lite SRAM responder with independent read/write FSMs, byte strobes and DECERR decode.
// Define YSYX_23060124_SRAM_RAND_DELAY_EN to add 0-7 LFSR-driven extra cycles of response latency.
module ysyx_23060124_axi_sram_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_AW     = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    RD_LATENCY = 1,
  parameter int                    WR_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int                  STRB_W    = DATA_WIDTH / 8;
  localparam int                  CNT_W     = 16;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(1) << (MEM_AW + 2);
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DELAY, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_t;

  logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];

  w_state_t              r_w_state;
  logic                  r_awready, r_wready, r_bvalid;
  logic                  r_aw_held, r_w_held;
  logic [1:0]            r_bresp;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;

  r_state_t              r_r_state;
  logic                  r_arready, r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [ADDR_WIDTH-1:0] r_ar_addr;

  logic                  w_aw_hs, w_w_hs, w_aw_ok, w_w_ok, w_ar_hs;
  logic [ADDR_WIDTH-1:0] w_wr_off, w_rd_off;
  logic                  w_wr_hit, w_rd_hit, w_wr_commit;
  logic [MEM_AW-1:0]     w_wr_idx, w_rd_idx;
  logic [CNT_W-1:0]      w_extra, w_wr_load, w_rd_load;

`ifdef YSYX_23060124_SRAM_RAND_DELAY_EN
  // Galois form of x^16+x^14+x^13+x^11, shifting right.
  logic [15:0] r_lfsr;
  always_ff @(posedge clk) begin
    if (!i_rst_n) r_lfsr <= 16'hACE1;
    else          r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end
  assign w_extra = CNT_W'(r_lfsr[2:0]);
`else
  assign w_extra = '0;
`endif

  assign w_wr_load = CNT_W'(WR_LATENCY - 1) + w_extra;
  assign w_rd_load = CNT_W'(RD_LATENCY - 1) + w_extra;

  // Unsigned offset wraps for addresses below the base, so one compare covers both bounds.
  assign w_wr_off = r_aw_addr - BASE_ADDR;
  assign w_rd_off = r_ar_addr - BASE_ADDR;
  assign w_wr_hit = {1'b0, w_wr_off} < MEM_BYTES;
  assign w_rd_hit = {1'b0, w_rd_off} < MEM_BYTES;
  assign w_wr_idx = w_wr_off[MEM_AW+1:2];
  assign w_rd_idx = w_rd_off[MEM_AW+1:2];

  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs  = S_AXI_WVALID  & r_wready;
  assign w_aw_ok = r_aw_held | w_aw_hs;
  assign w_w_ok  = r_w_held  | w_w_hs;
  assign w_ar_hs = S_AXI_ARVALID & r_arready;

  assign w_wr_commit = i_rst_n && (r_w_state == W_DELAY) && (r_wr_cnt == '0) && w_wr_hit;

  // NOTE: the array has no reset so it maps onto plain SRAM; its contents survive i_rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (r_wstrb[i]) r_mem[w_wr_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_w_state == W_IDLE && w_aw_hs) r_aw_addr <= S_AXI_AWADDR;
    if (r_w_state == W_IDLE && w_w_hs) begin
      r_wdata <= S_AXI_WDATA;
      r_wstrb <= S_AXI_WSTRB;
    end
    if (r_r_state == R_IDLE && w_ar_hs) r_ar_addr <= S_AXI_ARADDR;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_w_state <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_wr_cnt  <= '0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (w_aw_ok && w_w_ok) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_wr_cnt  <= w_wr_load;
            r_w_state <= W_DELAY;
          end else begin
            r_aw_held <= w_aw_ok;
            r_w_held  <= w_w_ok;
            r_awready <= ~w_aw_ok;
            r_wready  <= ~w_w_ok;
          end
        end
        W_DELAY: begin
          if (r_wr_cnt == '0) begin
            r_bresp   <= w_wr_hit ? RESP_OKAY : RESP_DECERR;
            r_bvalid  <= 1'b1;
            r_w_state <= W_RESP;
          end else begin
            r_wr_cnt <= r_wr_cnt - CNT_W'(1);
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_w_state <= W_IDLE;
          end
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the memory write above is non-blocking, so a same-edge sample here sees the old word.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_r_state <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_rd_cnt  <= '0;
    end else begin
      case (r_r_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rd_cnt  <= w_rd_load;
            r_r_state <= R_DELAY;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DELAY: begin
          if (r_rd_cnt == '0) begin
            r_rdata   <= w_rd_hit ? r_mem[w_rd_idx] : '0;
            r_rresp   <= w_rd_hit ? RESP_OKAY : RESP_DECERR;
            r_rvalid  <= 1'b1;
            r_r_state <= R_RESP;
          end else begin
            r_rd_cnt <= r_rd_cnt - CNT_W'(1);
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_r_state <= R_IDLE;
          end
        end
        default: r_r_state <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;

endmodule

// File: tb/tb_ysyx_23060124_axi_sram_slave.sv
// Self-checking bench for the AXI4-Lite SRAM responder: directed scenarios plus randomized
// traffic checked against a word-addressed associative-array model of the memory map.
module tb_ysyx_23060124_axi_sram_slave;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          MAW  = 12;
  localparam int          RDL  = 1;
  localparam int          WRL  = 1;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam longint      MEM_END = longint'({32'h0, BASE}) + (longint'(4) << MAW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic          s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic [DW-1:0] s_wdata = '0;
  logic [3:0]    s_wstrb = '0;
  logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]    s_bresp, s_rresp;
  logic [DW-1:0] s_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_mem [int];

  always #5 clk = ~clk;

  ysyx_23060124_axi_sram_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW), .BASE_ADDR(BASE),
    .RD_LATENCY(RDL), .WR_LATENCY(WRL)
  ) dut (
    .clk(clk), .i_rst_n(rst_n),
    .S_AXI_AWADDR(s_awaddr), .S_AXI_AWVALID(s_awvalid), .S_AXI_AWREADY(s_awready),
    .S_AXI_WDATA(s_wdata), .S_AXI_WSTRB(s_wstrb), .S_AXI_WVALID(s_wvalid), .S_AXI_WREADY(s_wready),
    .S_AXI_BRESP(s_bresp), .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(s_bready),
    .S_AXI_ARADDR(s_araddr), .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready),
    .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready)
  );

  function automatic bit model_hit(input logic [31:0] a);
    return longint'({32'h0, a}) >= longint'({32'h0, BASE}) && longint'({32'h0, a}) < MEM_END;
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!model_hit(a)) return 32'h0;
    return model_mem.exists(model_idx(a)) ? model_mem[model_idx(a)] : 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!model_hit(a)) return;
    w = model_read(a);
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model_mem[model_idx(a)] = w;
  endfunction

  // lead > 0: W is offered lead cycles before AW; lead < 0: AW leads. Entered and left at a negedge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdelay, input string tag);
    bit aw_done, w_done, aw_now, w_now;
    int cyc, lat;
    logic [1:0] exp_resp, resp0;
    exp_resp = model_hit(a) ? 2'b00 : 2'b11;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_bready = 0;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      s_awvalid = !aw_done && (lead <= 0 || cyc >= lead);
      s_wvalid  = !w_done && (lead >= 0 || cyc >= -lead);
      checks++;
      if ({s_awready, s_wready, s_bvalid} !== {!aw_done, !w_done, 1'b0}) begin
        failures++;
        $display("FAIL %s ready_state: got aw/w/b=%b%b%b expected %b%b0", tag,
                 s_awready, s_wready, s_bvalid, !aw_done, !w_done);
      end
      aw_now = s_awvalid && s_awready;
      w_now  = s_wvalid && s_wready;
      @(posedge clk); @(negedge clk);
      aw_done |= aw_now; w_done |= w_now; cyc++;
    end
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if (!(aw_done && w_done)) begin
      failures++;
      $display("FAIL %s handshake_timeout: got aw/w done=%b%b expected 11", tag, aw_done, w_done);
      return;
    end
    lat = 0;
    while (!s_bvalid && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== WRL) begin
      failures++; $display("FAIL %s b_latency: got %0d expected %0d", tag, lat, WRL);
    end
    checks++;
    if (s_bresp !== exp_resp) begin
      failures++; $display("FAIL %s bresp: got %b expected %b", tag, s_bresp, exp_resp);
    end
    resp0 = s_bresp;
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      checks++;
      if ({s_bvalid, s_bresp} !== {1'b1, resp0}) begin
        failures++; $display("FAIL %s b_hold: got v/resp=%b/%b expected 1/%b", tag, s_bvalid, s_bresp, resp0);
      end
    end
    s_bready = 1;
    @(posedge clk); @(negedge clk);
    s_bready = 0;
    checks++;
    if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin
      failures++;
      $display("FAIL %s b_release: got bvalid/awready/wready=%b%b%b expected 011", tag, s_bvalid, s_awready, s_wready);
    end
    model_write(a, d, s);
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdelay, input string tag);
    int cyc, lat;
    logic [31:0] exp_d, d0;
    logic [1:0] exp_r, r0;
    exp_d = model_read(a);
    exp_r = model_hit(a) ? 2'b00 : 2'b11;
    s_araddr = a; s_arvalid = 1; s_rready = 0; cyc = 0;
    while (!s_arready && cyc < 40) begin @(negedge clk); cyc++; end
    checks++;
    if (!s_arready) begin
      failures++; s_arvalid = 0;
      $display("FAIL %s ar_timeout: got arready=0 expected 1", tag);
      return;
    end
    @(posedge clk); @(negedge clk);
    s_arvalid = 0;
    lat = 0;
    while (!s_rvalid && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== RDL) begin
      failures++; $display("FAIL %s r_latency: got %0d expected %0d", tag, lat, RDL);
    end
    checks++;
    if ({s_rresp, s_rdata} !== {exp_r, exp_d}) begin
      failures++;
      $display("FAIL %s rdata: got resp=%b data=%h expected resp=%b data=%h", tag, s_rresp, s_rdata, exp_r, exp_d);
    end
    d0 = s_rdata; r0 = s_rresp;
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      checks++;
      if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, r0, d0}) begin
        failures++; $display("FAIL %s r_hold: got v=%b data=%h expected v=1 data=%h", tag, s_rvalid, s_rdata, d0);
      end
    end
    s_rready = 1;
    @(posedge clk); @(negedge clk);
    s_rready = 0;
    checks++;
    if ({s_rvalid, s_arready} !== 2'b01) begin
      failures++; $display("FAIL %s r_release: got rvalid/arready=%b%b expected 01", tag, s_rvalid, s_arready);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b%b%b v=%b%b bresp=%b rresp=%b rdata=%h expected all 0",
               s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata);
    end
    rst_n = 1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid} !== 5'b11100) begin
      failures++;
      $display("FAIL reset_release: got rdy/valid=%b%b%b%b%b expected 11100",
               s_awready, s_wready, s_arready, s_bvalid, s_rvalid);
    end
  endtask

  task automatic test_write_read;
    axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, "wr_word");
    axi_read(32'h8000_0010, 0, "rd_word");
  endtask

  task automatic test_strobes;
    axi_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, "strb_pre");
    axi_write(32'h8000_0020, 32'h0000_AB00, 4'b0010, 0, 0, "strb_wr");
    axi_read(32'h8000_0020, 0, "strb_rd");
    checks++;
    if (model_read(32'h8000_0020) !== 32'h1122_AB44) begin
      failures++; $display("FAIL strb_model: got %h expected 1122ab44", model_read(32'h8000_0020));
    end
  endtask

  task automatic test_decoupled;
    axi_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF, 3, 4, "decoup_w_first");
    axi_write(32'h8000_0034, 32'h0BAD_CAFE, 4'hF, -2, 1, "decoup_aw_first");
    axi_read(32'h8000_0030, 2, "decoup_rd0");
    axi_read(32'h8000_0034, 0, "decoup_rd1");
  endtask

  task automatic test_out_of_range;
    axi_write(32'h8000_0000, 32'h5A5A_0001, 4'hF, 0, 0, "oor_pre_lo");
    axi_write(32'h8000_3FFC, 32'hA5A5_0002, 4'hF, 0, 0, "oor_pre_hi");
    axi_read(32'h7FFF_FFFC, 0, "oor_rd_below");
    axi_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, 0, "oor_wr_above");
    axi_read(32'h8000_4000, 1, "oor_rd_above");
    axi_read(32'h8000_0000, 0, "oor_unchanged_lo");
    axi_read(32'h8000_3FFC, 0, "oor_top_word");
  endtask

  task automatic test_concurrent;
    logic [31:0] a;
    a = 32'h8000_0100;
    axi_write(a, 32'd5, 4'hF, 0, 0, "conc_pre");
    s_awaddr = a; s_wdata = 32'd9; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    s_araddr = a; s_arvalid = 1; s_bready = 1; s_rready = 1;
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      failures++; $display("FAIL conc_ready: got %b%b%b expected 111", s_awready, s_wready, s_arready);
    end
    @(posedge clk); @(negedge clk);
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({s_bvalid, s_rvalid, s_rresp, s_rdata} !== {2'b11, 2'b00, 32'd5}) begin
      failures++;
      $display("FAIL conc_read_first: got b/r valid=%b%b data=%h expected 11 data=00000005", s_bvalid, s_rvalid, s_rdata);
    end
    model_write(a, 32'd9, 4'hF);
    @(posedge clk); @(negedge clk);
    s_bready = 0; s_rready = 0;
    checks++;
    if ({s_bvalid, s_rvalid} !== 2'b00) begin
      failures++; $display("FAIL conc_release: got b/r valid=%b%b expected 00", s_bvalid, s_rvalid);
    end
    axi_read(a, 0, "conc_new");
  endtask

  task automatic test_reset_mid_read;
    int seen;
    s_araddr = 32'h8000_0010; s_arvalid = 1; s_rready = 1;
    checks++;
    if (s_arready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_arready: got %b expected 1", s_arready);
    end
    @(posedge clk); @(negedge clk);
    s_arvalid = 0;
    rst_n = 0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({s_rvalid, s_arready, s_awready, s_wready} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid_during: got rvalid/arready/awready/wready=%b%b%b%b expected 0000",
               s_rvalid, s_arready, s_awready, s_wready);
    end
    rst_n = 1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({s_arready, s_rvalid} !== 2'b10) begin
      failures++; $display("FAIL rst_mid_release: got arready/rvalid=%b%b expected 10", s_arready, s_rvalid);
    end
    seen = 0;
    repeat (5) begin @(negedge clk); if (s_rvalid) seen++; end
    s_rready = 0;
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL rst_mid_spurious: got %0d rvalid cycles expected 0", seen);
    end
    axi_read(32'h8000_0010, 0, "rst_mem_kept");
  endtask

  task automatic test_random;
    logic [31:0] pool [8];
    logic [31:0] oor [4];
    logic [31:0] a;
    oor = '{BASE - 32'd4, BASE + 32'h4000, 32'h0000_1000, 32'hFFFF_FFFC};
    pool[0] = BASE;
    pool[1] = BASE + 32'h3FFC;
    for (int i = 2; i < 8; i++) pool[i] = BASE + (32'($urandom_range(0, 4095)) << 2);
    for (int i = 0; i < 8; i++) axi_write(pool[i], $urandom, 4'hF, 0, 0, "rand_init");
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 7) == 0) ? oor[$urandom_range(0, 3)] : pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                  int'($urandom_range(0, 3)), "rand_wr");
      else
        axi_read(a, int'($urandom_range(0, 3)), "rand_rd");
    end
    for (int i = 0; i < 8; i++) axi_read(pool[i], 0, "rand_final");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_write_read;
    test_strobes;
    test_decoupled;
    test_out_of_range;
    test_concurrent;
    test_reset_mid_read;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
